// File: rtl/omem_if.sv
// Router-side bundle for omem_sync: packet in, packet out and the spike
// readout stream. The router/bench drives the master side.
interface omem_if #(
   parameter int PKT_W  = 33,
   parameter int TS_W   = 2,
   parameter int ADDR_W = 9
);
   logic              in_valid;
   logic              in_ready;
   logic [PKT_W-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [PKT_W-1:0]  out_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [TS_W-1:0]   rd_ts;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_spike;
   logic              done;
   logic              err;

   modport master (
      output in_valid, in_data, out_ready, rd_ready,
      input  in_ready, out_valid, out_data, rd_valid, rd_ts, rd_addr, rd_spike, done, err
   );

   modport slave (
      input  in_valid, in_data, out_ready, rd_ready,
      output in_ready, out_valid, out_data, rd_valid, rd_ts, rd_addr, rd_spike, done, err
   );
endinterface

// File: rtl/omem_sync.sv
// omem_sync: output memory for the spiking-convolution array.
// Collects spike bits / residual potentials per timestep, answers
// previous-timestep requests, broadcasts timestep-done packets and streams
// all spikes out after the last timestep.
// Build option: define OMEM_RESIDUE_EN to build the residue banks; without
// it responses carry zero potential and store potentials are ignored.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RECV  | accepting packets (stores / requests / ignored opcodes)
// ST_RESP  | holding a request response until out_ready
// ST_BCAST | sending opcode-15 packets to nodes 0..NUM_NODES-1
// ST_DRAIN | streaming (ts, addr, spike) words on the rd port
// ST_DONE  | finished; done=1, input closed until reset
module omem_sync #(
   parameter int NUM_SPE   = 5,
   parameter int OUT_DIM   = 21,
   parameter int NUM_TS    = 2,
   parameter int POT_WIDTH = 13,
   parameter int NUM_NODES = 11,
   parameter int PKT_W     = 33
) (
   input logic   clk,
   input logic   rst_n,
   omem_if.slave bus
);
   localparam int DEPTH  = OUT_DIM * OUT_DIM;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int TS_W   = $clog2(NUM_TS) + 1;
   localparam int PTR_W  = $clog2(DEPTH + NUM_SPE);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0]  STEP_P    = PTR_W'(NUM_SPE);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);
   localparam logic [TS_W-1:0]   LAST_TS   = TS_W'(NUM_TS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [3:0]        LAST_NODE = 4'(NUM_NODES - 1);

   typedef enum logic [2:0] {ST_RECV, ST_RESP, ST_BCAST, ST_DRAIN, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   ptr_q [NUM_SPE];
   logic [PTR_W-1:0]   ptr_d [NUM_SPE];
   logic               err_q, err_d;
   logic [PKT_W-1:0]   out_data_q, out_data_d;
   logic [3:0]         node_q, node_d;
   logic [TS_W-1:0]    rd_ts_q, rd_ts_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;

   logic [DEPTH-1:0]   spike_q [NUM_TS];

   logic [3:0]         opcode;
   logic [2:0]         spe_idx;
   logic               is_spe;
   logic [PTR_W-1:0]   sel_ptr;
   logic [ADDR_W-1:0]  mem_addr;
   logic               wr_en;
   logic               swap;
   logic               prev_spk;
   logic               rd_spk;
   logic [POT_WIDTH-1:0] resp_pot;
   logic [PKT_W-1:0]   rsp_pkt;
   logic               unused_in;

   assign opcode    = bus.in_data[28:25];
   assign spe_idx   = opcode[3:1];
   assign is_spe    = {1'b0, spe_idx} < 4'(NUM_SPE);
   assign mem_addr  = sel_ptr[ADDR_W-1:0];
   assign unused_in = ^bus.in_data;

   // Pointer of the addressed SPE and spike lookups for response / readout.
   always_comb begin
      sel_ptr  = '0;
      prev_spk = 1'b0;
      rd_spk   = 1'b0;
      for (int k = 0; k < NUM_SPE; k++) begin
         if (spe_idx == 3'(k)) sel_ptr = ptr_q[k];
      end
      for (int t = 0; t < NUM_TS; t++) begin
         if (ts_q == TS_W'(t + 2)) prev_spk = spike_q[t][mem_addr];
         if (rd_ts_q == TS_W'(t + 1)) rd_spk = spike_q[t][rd_addr_q];
      end
   end

   // Request response: data fields are zero in the first timestep or once
   // the SPE has run past the end of the map.
   always_comb begin
      rsp_pkt        = '0;
      rsp_pkt[32:29] = bus.in_data[4:1];
      if ((ts_q != TS_W'(1)) && (sel_ptr < DEPTH_P)) begin
         rsp_pkt[POT_WIDTH:1] = resp_pot;
         rsp_pkt[0]           = prev_spk;
      end
   end

   // Next-state logic for the sequencer and all its counters.
   always_comb begin
      state_d    = state_q;
      ts_d       = ts_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      out_data_d = out_data_q;
      node_d     = node_q;
      rd_ts_d    = rd_ts_q;
      rd_addr_d  = rd_addr_q;
      for (int k = 0; k < NUM_SPE; k++) ptr_d[k] = ptr_q[k];
      wr_en = 1'b0;
      swap  = 1'b0;
      case (state_q)
         ST_RECV: begin
            if (bus.in_valid && is_spe && !opcode[0]) begin
               if (sel_ptr >= DEPTH_P) begin
                  err_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  for (int k = 0; k < NUM_SPE; k++) begin
                     if (spe_idx == 3'(k)) ptr_d[k] = sel_ptr + STEP_P;
                  end
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_CNT) begin
                     if (ts_q < LAST_TS) begin
                        state_d    = ST_BCAST;
                        node_d     = 4'd0;
                        out_data_d = {4'd0, 4'hf, 25'd0};
                     end else begin
                        state_d   = ST_DRAIN;
                        rd_ts_d   = TS_W'(1);
                        rd_addr_d = '0;
                     end
                  end
               end
            end else if (bus.in_valid && is_spe && opcode[0]) begin
               state_d    = ST_RESP;
               out_data_d = rsp_pkt;
            end
         end
         ST_RESP: begin
            if (bus.out_ready) state_d = ST_RECV;
         end
         ST_BCAST: begin
            if (bus.out_ready) begin
               if (node_q == LAST_NODE) begin
                  swap    = 1'b1;
                  ts_d    = ts_q + TS_W'(1);
                  cnt_d   = '0;
                  state_d = ST_RECV;
                  for (int k = 0; k < NUM_SPE; k++) ptr_d[k] = PTR_W'(k);
               end else begin
                  node_d     = node_q + 4'd1;
                  out_data_d = {node_q + 4'd1, 4'hf, 25'd0};
               end
            end
         end
         ST_DRAIN: begin
            if (bus.rd_ready) begin
               if (rd_addr_q == LAST_ADDR) begin
                  rd_addr_d = '0;
                  if (rd_ts_q == LAST_TS) state_d = ST_DONE;
                  else                    rd_ts_d = rd_ts_q + TS_W'(1);
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: state_d = ST_RECV;
      endcase
   end

   // Sequencer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RECV;
         ts_q       <= TS_W'(1);
         cnt_q      <= '0;
         err_q      <= 1'b0;
         out_data_q <= '0;
         node_q     <= 4'd0;
         rd_ts_q    <= TS_W'(1);
         rd_addr_q  <= '0;
         for (int k = 0; k < NUM_SPE; k++) ptr_q[k] <= PTR_W'(k);
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         out_data_q <= out_data_d;
         node_q     <= node_d;
         rd_ts_q    <= rd_ts_d;
         rd_addr_q  <= rd_addr_d;
         for (int k = 0; k < NUM_SPE; k++) ptr_q[k] <= ptr_d[k];
      end
   end

   // Spike bank per timestep, written at the accepting edge of a store.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TS; t++) spike_q[t] <= '0;
      end else begin
         for (int t = 0; t < NUM_TS; t++) begin
            if (wr_en && (ts_q == TS_W'(t + 1))) spike_q[t][mem_addr] <= bus.in_data[0];
         end
      end
   end

`ifdef OMEM_RESIDUE_EN
   logic [POT_WIDTH-1:0] res_cur_q  [DEPTH];
   logic [POT_WIDTH-1:0] res_prev_q [DEPTH];

   // Current-timestep residues; copied wholesale to the previous bank at
   // the end of each broadcast (stores cannot happen in that cycle).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            res_cur_q[i]  <= '0;
            res_prev_q[i] <= '0;
         end
      end else begin
         if (wr_en) res_cur_q[mem_addr] <= bus.in_data[POT_WIDTH:1];
         if (swap) begin
            for (int i = 0; i < DEPTH; i++) res_prev_q[i] <= res_cur_q[i];
         end
      end
   end

   assign resp_pot = res_prev_q[mem_addr];
`else
   logic unused_swap;
   assign unused_swap = swap;
   assign resp_pot    = '0;
`endif

   assign bus.in_ready  = rst_n && (state_q == ST_RECV);
   assign bus.out_valid = (state_q == ST_RESP) || (state_q == ST_BCAST);
   assign bus.out_data  = out_data_q;
   assign bus.rd_valid  = (state_q == ST_DRAIN);
   assign bus.rd_ts     = rd_ts_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.rd_spike  = (state_q == ST_DRAIN) && rd_spk;
   assign bus.done      = (state_q == ST_DONE);
   assign bus.err       = err_q;
endmodule

// File: tb/tb_omem_sync.sv
// Scoreboard bench for omem_sync: a behavioural model predicts every
// response, broadcast and readout word; the DUT output is popped and compared.
module tb_omem_sync;
   localparam int NUM_SPE   = 5;
   localparam int DEPTH     = 441;
   localparam int NUM_TS    = 2;
   localparam int NUM_NODES = 11;
   localparam int POT_WIDTH = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   omem_if #(.PKT_W(33), .TS_W(2), .ADDR_W(9)) bus ();

   omem_sync dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [32:0] out_q [$];
   logic [11:0] rd_q  [$];

   int ptr_m [NUM_SPE];
   int cnt_m;
   int ts_m;
   bit spk_m [NUM_TS][DEPTH];
   int res_cur_m  [DEPTH];
   int res_prev_m [DEPTH];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_SPE; k++) ptr_m[k] = k;
      cnt_m = 0;
      ts_m  = 1;
      for (int i = 0; i < DEPTH; i++) begin
         res_cur_m[i]  = 0;
         res_prev_m[i] = 0;
         for (int t = 0; t < NUM_TS; t++) spk_m[t][i] = 1'b0;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_pkt(input logic [32:0] p);
      int g;
      g = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = p;
      while (!bus.in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!bus.in_ready) begin
         check("in_ready_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic store(input int k, input bit spk, input int pot);
      logic [32:0] p;
      p = '0;
      p[28:25]       = 4'(2 * k);
      p[POT_WIDTH:1] = POT_WIDTH'(pot);
      p[0]           = spk;
      if (ptr_m[k] < DEPTH) begin
         spk_m[ts_m-1][ptr_m[k]] = spk;
         res_cur_m[ptr_m[k]]     = pot;
         ptr_m[k] += NUM_SPE;
         cnt_m++;
         if (cnt_m == DEPTH) begin
            if (ts_m < NUM_TS) begin
               for (int b = 0; b < NUM_NODES; b++) out_q.push_back({4'(b), 4'hf, 25'd0});
            end else begin
               for (int t = 0; t < NUM_TS; t++)
                  for (int a = 0; a < DEPTH; a++)
                     rd_q.push_back({2'(t + 1), 9'(a), spk_m[t][a]});
            end
         end
      end
      send_pkt(p);
   endtask

   task automatic take_out(input int n);
      int g;
      logic [32:0] e;
      for (int i = 0; i < n; i++) begin
         g = 0;
         while (!bus.out_valid && g < 50) begin
            @(negedge clk);
            g++;
         end
         if (!bus.out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
         end
         if (out_q.size() == 0) begin
            check("out_extra", 1, 0);
            return;
         end
         e = out_q.pop_front();
         check("out_data", bus.out_data, e);
         @(negedge clk);
      end
   endtask

   task automatic request(input int k, input int id);
      logic [32:0] p, e;
      p = '0;
      e = '0;
      p[28:25] = 4'(2 * k + 1);
      p[4:1]   = 4'(id);
      e[32:29] = 4'(id);
      if (ts_m > 1 && ptr_m[k] < DEPTH) begin
         e[0] = spk_m[ts_m-2][ptr_m[k]];
`ifdef OMEM_RESIDUE_EN
         e[POT_WIDTH:1] = POT_WIDTH'(res_prev_m[ptr_m[k]]);
`endif
      end
      out_q.push_back(e);
      send_pkt(p);
      check("resp_latency", bus.out_valid, 1);
      take_out(1);
   endtask

   task automatic bcast(input int hold_at);
      check("bcast_start", bus.out_valid, 1);
      for (int b = 0; b < NUM_NODES; b++) begin
         if (b == hold_at) begin
            bus.out_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               check("hold_valid", bus.out_valid, 1);
               check("hold_data", bus.out_data, out_q[0]);
            end
            bus.out_ready = 1'b1;
         end
         take_out(1);
      end
      check("bcast_end", bus.out_valid, 0);
      check("bcast_in_ready", bus.in_ready, 1);
      ts_m++;
      cnt_m = 0;
      for (int k = 0; k < NUM_SPE; k++) ptr_m[k] = k;
      for (int i = 0; i < DEPTH; i++) res_prev_m[i] = res_cur_m[i];
   endtask

   task automatic drain(input int nw);
      int got, g;
      logic [11:0] e;
      got = 0;
      g   = 0;
      check("drain_start", bus.rd_valid, 1);
      while (got < nw && g < 20000) begin
         bus.rd_ready = ($urandom_range(0, 3) != 0);
         if (bus.rd_valid && bus.rd_ready) begin
            if (rd_q.size() == 0) begin
               check("rd_extra", 1, 0);
               break;
            end
            e = rd_q.pop_front();
            check("rd_word", {bus.rd_ts, bus.rd_addr, bus.rd_spike}, e);
            got++;
         end
         @(negedge clk);
         g++;
      end
      bus.rd_ready = 1'b0;
      if (got < nw) check("drain_count", got, nw);
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_ts", bus.rd_ts, 1);
      check("rst_rd_addr", bus.rd_addr, 0);
      check("rst_rd_spike", bus.rd_spike, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.rd_ready  = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);

      // Timestep 1: zero-data request, full round-robin fill, broadcast.
      request(0, 3);
      for (int n = 0; n < DEPTH; n++) store(n % NUM_SPE, 1'(n & 1), n);
      check("ts1_err", bus.err, 0);
      bcast(4);

      // Timestep 2: partial fill by SPE 2, then a previous-timestep request.
      store(2, 1'(~2 & 1), 1002);
      store(2, 1'(~7 & 1), 1007);
      store(2, 1'(~12 & 1), 1012);
      request(2, 2);
      for (int n = 0; n < DEPTH; n++) begin
         if (n != 2 && n != 7 && n != 12) store(n % NUM_SPE, 1'(~n & 1), n + 1000);
      end
      drain(2 * DEPTH);
      check("done_set", bus.done, 1);
      check("done_in_ready", bus.in_ready, 0);
      check("done_rd_valid", bus.rd_valid, 0);

      // Second run: overflowing pointer, then reset in the middle of DRAIN.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      out_q.delete();
      rd_q.delete();
      @(negedge clk);
      for (int i = 0; i < 90; i++) begin
         store(0, 1'b1, i);
         if (i >= 87) check("err_overflow", bus.err, (i >= 89) ? 1 : 0);
      end
      for (int n = 0; n < DEPTH; n++) begin
         if (n % NUM_SPE != 0) begin
            store(n % NUM_SPE, 1'(n & 1), n);
            if (n >= 436) check("ts_end_point", bus.out_valid, (cnt_m == DEPTH) ? 1 : 0);
         end
      end
      bcast(-1);
      for (int n = 0; n < DEPTH; n++) store(n % NUM_SPE, 1'(~n & 1), n);
      drain(25);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      model_reset();
      rd_q.delete();
      out_q.delete();
      @(negedge clk);
      check("rerun_in_ready", bus.in_ready, 1);
      request(1, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
